// File: rtl/obp_pkg.sv
// Shared types and helpers for the output-layer backprop sequencer.
// Build option: define OBP_SATURATE_EN to clamp updated weights instead of
// wrapping them to W_W bits.
package obp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Error width: both operands are zero-extended, so one extra bit holds the sign.
    function automatic int err_width(input int x_w, input int final_w);
        return ((x_w > final_w) ? x_w : final_w) + 1;
    endfunction

    // Product width: signed error times a zero-extended (non-negative) activation.
    function automatic int prod_width(input int x_w, input int final_w, input int h_w);
        return err_width(x_w, final_w) + h_w + 1;
    endfunction

    // Fit a wide signed value into w_w bits; the caller keeps the low w_w bits.
    function automatic logic signed [63:0] fit_val(input logic signed [63:0] v, input int w_w);
`ifdef OBP_SATURATE_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w_w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
`else
        // Wrap-around: keep the low w_w bits, re-sign-extended.
        return (v <<< (64 - w_w)) >>> (64 - w_w);
`endif
    endfunction

endpackage

// File: rtl/obp_update_lane.sv
// Stage-B weight update: new = w - (prod >>> LR_SHIFT), then fit to W_W bits.
// Purely combinational; the top registers the result into the addressed channel.
module obp_update_lane
    import obp_pkg::*;
#(
    parameter int W_W      = 8,
    parameter int PROD_W   = 31,
    parameter int LR_SHIFT = 19
) (
    input  logic signed [W_W-1:0]    w,
    input  logic signed [PROD_W-1:0] prod,
    output logic        [W_W-1:0]    new_w
);

    localparam int D_W = ((PROD_W > W_W) ? PROD_W : W_W) + 1;

    logic signed [PROD_W-1:0] step;
    logic signed [D_W-1:0]    diff;
    logic signed [63:0]       wide;
    logic signed [63:0]       fitted;

    // Floor-shift the gradient, subtract at full width, then fit.
    always_comb begin
        step   = prod >>> LR_SHIFT;
        diff   = D_W'(w) - D_W'(step);
        wide   = 64'(diff);
        fitted = fit_val(wide, W_W);
        new_w  = W_W'(fitted);
    end

endmodule

// File: rtl/output_backprop_seq.sv
// Output-layer backprop: updates N_HID weights one channel per cycle through a
// 2-stage pipeline (A: error*activation, B: shift/subtract/fit).
// Build option: OBP_SATURATE_EN selects clamping instead of wrap in the fit.
module output_backprop_seq
    import obp_pkg::*;
#(
    parameter int X_W      = 4,
    parameter int FINAL_W  = 19,
    parameter int H_W      = 10,
    parameter int W_W      = 8,
    parameter int N_HID    = 4,
    parameter int LR_SHIFT = 19
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [X_W-1:0]         target_i,
    input  logic [FINAL_W-1:0]     final_i,
    input  logic [N_HID*H_W-1:0]   hidden_i,
    input  logic [N_HID*W_W-1:0]   w_i,
    input  logic                   zero_weight_reset_i,
    output logic [N_HID*W_W-1:0]   w_o,
    output logic                   busy_o,
    output logic                   b_end_o
);

    localparam int E_W    = err_width(X_W, FINAL_W);
    localparam int PROD_W = prod_width(X_W, FINAL_W, H_W);
    localparam int IDX_W  = (N_HID > 1) ? $clog2(N_HID) : 1;

    state_t                   state, state_nx;
    logic [IDX_W-1:0]         idx, idx_q;
    logic                     last;
    logic                     vld_b;
    logic signed [E_W-1:0]    err_q;
    logic [N_HID*H_W-1:0]     hid_q;
    logic [N_HID*W_W-1:0]     w_snap;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [W_W-1:0]    lane_w;
    logic [W_W-1:0]           lane_new;

    assign last   = (idx == IDX_W'(N_HID - 1));
    assign lane_w = $signed(w_snap[idx_q*W_W +: W_W]);

    // State register; weight clear aborts the pass straight back to IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_i)
            state <= IDLE;
        else if (zero_weight_reset_i)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state: start only from IDLE, issue N_HID channels, one flush cycle, done.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en_i) state_nx = RUN;
            RUN:     if (last) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state: busy through DONE, done pulse in DONE only.
    always_comb begin
        busy_o  = (state != IDLE);
        b_end_o = (state == DONE);
    end

    // Snapshot on start, then stage A: one error*activation product per cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            idx    <= '0;
            idx_q  <= '0;
            vld_b  <= 1'b0;
            err_q  <= '0;
            hid_q  <= '0;
            w_snap <= '0;
            prod_q <= '0;
        end else if (zero_weight_reset_i) begin
            idx   <= '0;
            vld_b <= 1'b0;
        end else begin
            vld_b <= (state == RUN);
            if (state == IDLE && en_i) begin
                err_q  <= $signed(E_W'(target_i)) - $signed(E_W'(final_i));
                hid_q  <= hidden_i;
                w_snap <= w_i;
                idx    <= '0;
            end
            if (state == RUN) begin
                prod_q <= PROD_W'(err_q) * PROD_W'($signed({1'b0, hid_q[idx*H_W +: H_W]}));
                idx_q  <= idx;
                idx    <= last ? '0 : idx + IDX_W'(1);
            end
        end
    end

    obp_update_lane #(
        .W_W      (W_W),
        .PROD_W   (PROD_W),
        .LR_SHIFT (LR_SHIFT)
    ) u_lane (
        .w     (lane_w),
        .prod  (prod_q),
        .new_w (lane_new)
    );

    // Stage B write-back: only the channel in flight changes, others hold.
    always_ff @(posedge clk_i) begin
        if (!rst_i)
            w_o <= '0;
        else if (zero_weight_reset_i)
            w_o <= '0;
        else if (vld_b)
            w_o[idx_q*W_W +: W_W] <= lane_new;
    end

endmodule
